// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode encodings, state encoding, pipeline record and immediate helper
package cpu_pkg;
  localparam int OP_W = 5;
  localparam logic [1:0] CLS_R = 2'b00;
  localparam logic [1:0] CLS_I = 2'b01;
  localparam logic [1:0] CLS_I8 = 2'b10;
  localparam logic [1:0] CLS_J = 2'b11;
  localparam logic [OP_W-1:0] HALT_OP_DEF = 5'b11111;
  localparam logic [OP_W-1:0] NOP_OP = 5'b00000;
  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;
  typedef struct packed {
    logic valid;
    logic [OP_W-1:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic [15:0] npc;
  } dec_t;
  function automatic logic [15:0] dec_imm(input logic [15:0] ins);
    return ins[15:14] == CLS_I ? {{11{ins[4]}}, ins[4:0]} :
           ins[15:14] == CLS_I8 ? {{8{ins[7]}}, ins[7:0]} :
           ins[15:14] == CLS_J ? {{5{ins[10]}}, ins[10:0]} : 16'h0000;
  endfunction
endpackage

// File: rtl/regfile.sv
// regfile: 8x16 register file, one write port, two write-first bypassed read ports
module regfile #(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_en,
  input  logic [2:0]  i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic [2:0]  i_ra_addr,
  input  logic [2:0]  i_rb_addr,
  output logic [15:0] o_ra_data,
  output logic [15:0] o_rb_data
);
  logic [15:0] r_mem [8];
  logic w_we;
  assign w_we = i_wr_en && !(R0_ZERO && i_wr_addr == 3'd0);
  // storage: cleared on reset, otherwise written whenever the writeback port fires
  always_ff @(posedge clk) begin
    if (rst) r_mem <= '{default: 16'h0000};
    else if (w_we) r_mem[i_wr_addr] <= i_wr_data;
  end
  // reads: hardwired zero register first, then same-cycle write bypass, then storage
  always_comb begin
    o_ra_data = (R0_ZERO && i_ra_addr == 3'd0) ? 16'h0000 :
                (w_we && i_wr_addr == i_ra_addr) ? i_wr_data : r_mem[i_ra_addr];
    o_rb_data = (R0_ZERO && i_rb_addr == 3'd0) ? 16'h0000 :
                (w_we && i_wr_addr == i_rb_addr) ? i_wr_data : r_mem[i_rb_addr];
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode, load-use hazard detect, pipeline register and halt FSM
module decode_stage
  import cpu_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1,
  parameter logic [OP_W-1:0] HALT_OP = HALT_OP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Stall,
  input  logic            Flush,
  input  logic [15:0]     Instruct,
  input  logic [15:0]     NextPCIn,
  input  logic            WrEn,
  input  logic [2:0]      WrAddr,
  input  logic [15:0]     WrData,
  input  logic            ExMemRead,
  input  logic [2:0]      ExRd,
  output logic            HazardStall,
  output logic            Halt,
  output logic            Valid,
  output logic [OP_W-1:0] Op,
  output logic [2:0]      Rd,
  output logic [2:0]      Rs,
  output logic [2:0]      Rt,
  output logic [15:0]     RsData,
  output logic [15:0]     RtData,
  output logic [15:0]     Imm,
  output logic [15:0]     NextPCOut
);
  state_t r_state;
  dec_t r_dec;
  dec_t w_dec;
  logic r_halt;
  logic [OP_W-1:0] w_op;
  logic [1:0] w_cls;
  logic [2:0] w_rd, w_rs, w_rt, w_rt_src;
  logic w_nop, w_use_rs, w_use_rt, w_hz;
  logic [15:0] w_rs_data, w_rt_data;
  assign w_op = Instruct[15:11];
  assign w_cls = Instruct[15:14];
  assign w_rd = Instruct[10:8];
  assign w_rs = Instruct[7:5];
  assign w_rt = Instruct[4:2];
  assign w_nop = w_op == NOP_OP;
  // I8 instructions read their Rd through the second read port
  assign w_rt_src = w_cls == CLS_I8 ? w_rd : w_rt;
  regfile #(.R0_ZERO(R0_ZERO)) u_rf (
    .clk(clk),
    .rst(rst),
    .i_wr_en(WrEn),
    .i_wr_addr(WrAddr),
    .i_wr_data(WrData),
    .i_ra_addr(w_rs),
    .i_rb_addr(w_rt_src),
    .o_ra_data(w_rs_data),
    .o_rb_data(w_rt_data)
  );
  // source usage per class and load-use hazard against the load in execute
  always_comb begin
    w_use_rs = !w_nop && (w_cls == CLS_R || w_cls == CLS_I);
    w_use_rt = !w_nop && (w_cls == CLS_R || w_cls == CLS_I8);
    w_hz = ExMemRead && ExRd != 3'd0 && r_state == ST_RUN && !Flush &&
           ((w_use_rs && ExRd == w_rs) || (w_use_rt && ExRd == w_rt_src));
    w_dec = '{valid: 1'b1, op: w_op, rd: w_rd, rs: w_rs, rt: w_rt, rs_data: w_rs_data,
              rt_data: w_rt_data, imm: dec_imm(Instruct), npc: NextPCIn};
  end
  assign HazardStall = w_hz;
  // pipeline register and RUN/HALTED FSM: flush or halted bubbles, stall holds, hazard bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_halt <= 1'b0;
      r_dec <= '0;
    end else if (Flush || r_state == ST_HALTED) begin
      r_dec <= '0;
    end else if (!Stall) begin
      r_dec <= w_hz ? '0 : w_dec;
      if (!w_hz && w_op == HALT_OP) begin
        r_state <= ST_HALTED;
        r_halt <= 1'b1;
      end
    end
  end
  assign Halt = r_halt;
  assign Valid = r_dec.valid;
  assign Op = r_dec.op;
  assign Rd = r_dec.rd;
  assign Rs = r_dec.rs;
  assign Rt = r_dec.rt;
  assign RsData = r_dec.rs_data;
  assign RtData = r_dec.rt_data;
  assign Imm = r_dec.imm;
  assign NextPCOut = r_dec.npc;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven vectors with an expected-output queue for decode_stage
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b1, Stall = 1'b0, Flush = 1'b0, WrEn = 1'b0, ExMemRead = 1'b0;
  logic [15:0] Instruct = '0, NextPCIn = '0, WrData = '0;
  logic [2:0] WrAddr = '0, ExRd = '0;
  logic HazardStall, Halt, Valid;
  logic [4:0] Op;
  logic [2:0] Rd, Rs, Rt;
  logic [15:0] RsData, RtData, Imm, NextPCOut;
  int checks = 0, errors = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .Instruct(Instruct), .NextPCIn(NextPCIn),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .ExMemRead(ExMemRead), .ExRd(ExRd),
    .HazardStall(HazardStall), .Halt(Halt), .Valid(Valid), .Op(Op), .Rd(Rd), .Rs(Rs), .Rt(Rt),
    .RsData(RsData), .RtData(RtData), .Imm(Imm), .NextPCOut(NextPCOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall, flush;
    logic [15:0] instr, npc;
    logic wen;
    logic [2:0] waddr;
    logic [15:0] wdata;
    logic exmr;
    logic [2:0] exrd;
    logic hz, valid;
    logic [4:0] op;
    logic [2:0] rd;
    logic [15:0] rsd, rtd, imm, enpc;
    logic halt;
  } vec_t;

  typedef struct {
    string name;
    logic valid;
    logic [4:0] op;
    logic [2:0] rd;
    logic [15:0] rsd, rtd, imm, enpc;
    logic halt;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({e.name, ".valid"}, 16'(Valid), 16'(e.valid));
    chk({e.name, ".op"}, 16'(Op), 16'(e.op));
    chk({e.name, ".rd"}, 16'(Rd), 16'(e.rd));
    chk({e.name, ".rsdata"}, RsData, e.rsd);
    chk({e.name, ".rtdata"}, RtData, e.rtd);
    chk({e.name, ".imm"}, Imm, e.imm);
    chk({e.name, ".npc"}, NextPCOut, e.enpc);
    chk({e.name, ".halt"}, 16'(Halt), 16'(e.halt));
  endtask

  vec_t v[16];

  initial begin
    v[0]  = '{0,0,16'h0000,16'h0001,0,0,16'h0000,0,0, 0,1,5'h00,0,16'h0000,16'h0000,16'h0000,16'h0001,0};
    v[1]  = '{0,0,16'h096C,16'h0002,1,3,16'hBEEF,0,0, 0,1,5'h01,1,16'hBEEF,16'hBEEF,16'h0000,16'h0002,0};
    v[2]  = '{0,0,16'h090C,16'h0003,1,0,16'h1234,0,0, 0,1,5'h01,1,16'h0000,16'hBEEF,16'h0000,16'h0003,0};
    v[3]  = '{0,0,16'h4150,16'h0004,1,2,16'h5555,0,0, 0,1,5'h08,1,16'h5555,16'h0000,16'hFFF0,16'h0004,0};
    v[4]  = '{0,0,16'h4150,16'h0005,0,0,16'h0000,1,2, 1,0,5'h00,0,16'h0000,16'h0000,16'h0000,16'h0000,0};
    v[5]  = '{0,0,16'h4150,16'h0006,0,0,16'h0000,1,0, 0,1,5'h08,1,16'h5555,16'h0000,16'hFFF0,16'h0006,0};
    v[6]  = '{0,0,16'hC3FF,16'h0007,0,0,16'h0000,0,0, 0,1,5'h18,3,16'h0000,16'h0000,16'h03FF,16'h0007,0};
    v[7]  = '{0,0,16'h8380,16'h0008,0,0,16'h0000,1,3, 1,0,5'h00,0,16'h0000,16'h0000,16'h0000,16'h0000,0};
    v[8]  = '{0,0,16'h8380,16'h0009,0,0,16'h0000,1,4, 0,1,5'h10,3,16'h0000,16'hBEEF,16'hFF80,16'h0009,0};
    v[9]  = '{0,0,16'h096C,16'h0010,0,0,16'h0000,0,0, 0,1,5'h01,1,16'hBEEF,16'hBEEF,16'h0000,16'h0010,0};
    v[10] = '{1,0,16'h4150,16'h0020,0,0,16'h0000,0,0, 0,1,5'h01,1,16'hBEEF,16'hBEEF,16'h0000,16'h0010,0};
    v[11] = '{1,0,16'h096C,16'h0021,0,0,16'h0000,1,3, 1,1,5'h01,1,16'hBEEF,16'hBEEF,16'h0000,16'h0010,0};
    v[12] = '{1,1,16'h096C,16'h0022,0,0,16'h0000,1,3, 0,0,5'h00,0,16'h0000,16'h0000,16'h0000,16'h0000,0};
    v[13] = '{0,0,16'hF800,16'h0030,0,0,16'h0000,0,0, 0,1,5'h1F,0,16'h0000,16'h0000,16'h0000,16'h0030,1};
    v[14] = '{0,0,16'h096C,16'h0031,1,5,16'hAAAA,1,3, 0,0,5'h00,0,16'h0000,16'h0000,16'h0000,16'h0000,1};
    v[15] = '{0,0,16'h8380,16'h0032,0,0,16'h0000,0,0, 0,0,5'h00,0,16'h0000,16'h0000,16'h0000,16'h0000,1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.valid", 16'(Valid), 16'h0);
    chk("reset.op", 16'(Op), 16'h0);
    chk("reset.halt", 16'(Halt), 16'h0);
    chk("reset.npc", NextPCOut, 16'h0);
    chk("reset.hz", 16'(HazardStall), 16'h0);

    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      pop_cmp();
      Stall = v[i].stall; Flush = v[i].flush; Instruct = v[i].instr; NextPCIn = v[i].npc;
      WrEn = v[i].wen; WrAddr = v[i].waddr; WrData = v[i].wdata;
      ExMemRead = v[i].exmr; ExRd = v[i].exrd;
      #1;
      chk($sformatf("v%0d.hz", i), 16'(HazardStall), 16'(v[i].hz));
      sb.push_back('{$sformatf("v%0d", i), v[i].valid, v[i].op, v[i].rd,
                     v[i].rsd, v[i].rtd, v[i].imm, v[i].enpc, v[i].halt});
    end
    @(negedge clk);
    pop_cmp();

    Stall = 0; Flush = 0; WrEn = 0; ExMemRead = 0; ExRd = 0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_halted.halt", 16'(Halt), 16'h0);
    chk("rst_halted.valid", 16'(Valid), 16'h0);
    Instruct = 16'h08AC; NextPCIn = 16'h0040;
    #1;
    sb.push_back('{"post_rst", 1'b1, 5'h01, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 1'b0});
    @(negedge clk);
    pop_cmp();

    Instruct = 16'h0000; NextPCIn = 16'h0041;
    Stall = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; Stall = 1'b0;
    chk("rst_stall.valid", 16'(Valid), 16'h0);
    chk("rst_stall.npc", NextPCOut, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter R0_ZERO, default 1: register 0 SHALL read as 16'h0000 and ignore writes when 1.
REQ-002 Parameter HALT_OP, default 5'b11111: opcode value that SHALL be decoded as HALT.
REQ-003 clk  input  1  sole clock; all state on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 Stall  input  1  downstream stall; pipeline register holds.
REQ-006 Flush  input  1  redirect taken (inverse of NotBranchOrJump); current decode slot discarded.
REQ-007 Instruct  input  16  instruction from the fetch pipeline register.
REQ-008 NextPCIn  input  16  PC+1 of that instruction.
REQ-009 WrEn, WrAddr[2:0], WrData[15:0]  input  1/3/16  writeback port.
REQ-010 ExMemRead, ExRd[2:0]  input  1/3  load in execute and its destination.
REQ-011 HazardStall  output  1  combinational; drives FetchStall upstream.
REQ-012 Halt  output  1  registered; drives fetch Halt.
REQ-013 Valid, Op[4:0], Rd[2:0], Rs[2:0], Rt[2:0], RsData[15:0], RtData[15:0], Imm[15:0], NextPCOut[15:0]  output  registered decode results.

Function
REQ-014 Fields: Op=Instruct[15:11], Rd=[10:8], Rs=[7:5], Rt=[4:2].
REQ-015 Class by Op[4:3]: 00 R-type (uses Rs,Rt; Imm=0); 01 I-type (uses Rs; Imm=sext(Instruct[4:0])); 10 I8-type (uses Rd as source via Rt read port; Imm=sext(Instruct[7:0])); 11 J-type (no sources; Imm=sext(Instruct[10:0])).
REQ-016 Op=5'b00000 SHALL be NOP: no sources used, no hazard, Valid=1.
REQ-017 Register file 8x16; write on clk when WrEn; reads combinational with write-first bypass (same-cycle WrAddr match returns WrData, except register 0 when R0_ZERO=1).
REQ-018 HazardStall=1 iff ExMemRead & ExRd!=0 & ExRd equals a used source register, and state is RUN and not Flush.
REQ-019 Register update priority per edge: rst > Flush (load bubble) > Stall (hold all) > HazardStall (load bubble) > normal load.
REQ-020 Bubble SHALL set Valid=0, Op=0, Rd=Rs=Rt=0, data/Imm/NextPCOut=0.
REQ-021 Latency: an accepted instruction appears on outputs exactly 1 cycle later.
REQ-022 FSM RUN/HALTED: RUN->HALTED when Op==HALT_OP is loaded normally (not flushed/bubbled); HALT itself emitted with Valid=1; Halt asserted from that edge on.
REQ-023 In HALTED every edge SHALL load a bubble, HazardStall=0, Halt=1; only rst exits.
REQ-024 Stall and Flush together: Flush wins; HazardStall during Stall SHALL still assert but not change registers.
REQ-025 Register file writes SHALL proceed regardless of Stall, Flush, hazard or HALTED.

Reset
REQ-026 On rst edge: state=RUN, Halt=0, pipeline outputs = bubble values (Valid=0, all fields 0).
REQ-027 Register file contents SHALL reset to 16'h0000; rst mid-HALTED or mid-stall SHALL take priority same edge.

Structure
REQ-028 Shared package cpu_pkg SHALL hold opcode width, class encodings, HALT_OP default, NOP encoding, and the RUN/HALTED state encoding.
REQ-029 One sub-module regfile (8x16, one write, two bypassed reads) SHALL be instantiated; pipeline register and FSM live in decode_stage.

Verification
REQ-030 Reset, then Instruct=16'h0000 -> next cycle Valid=1, Op=0, HazardStall=0, Halt=0.
REQ-031 WrEn=1, WrAddr=3, WrData=16'hBEEF same cycle as R-type reading Rs=3 -> RsData=16'hBEEF next cycle; write to R0 then read -> 16'h0000.
REQ-032 ExMemRead=1, ExRd=2, I-type Rs=2 -> HazardStall=1 same cycle, next Valid=0; ExRd=0 -> HazardStall=0.
REQ-033 I-type with Instruct[4:0]=5'b10000 -> Imm=16'hFFF0; J-type imm11=11'h3FF -> Imm=16'h03FF.
REQ-034 Stall=1 and Flush=1 same edge with valid instruction -> outputs bubble; Stall alone -> outputs unchanged.
REQ-035 Instruct Op=5'b11111 -> next cycle Valid=1, Halt=1; subsequent instructions yield Valid=0 until rst, after which Halt=0.
